micro_sequencer: RTL and testbench
==================================

// Module: micro_sequencer
// PURPOSE
//  Micro-PC / next-address unit that sits directly upstream of the control store.
//  - Holds the registered micro-address `uaddr` that indexes the control-store ROM.
//  - Each cycle it selects the next address from one of three sources:
//    - the control word's next-address field [37:32],
//    - the opcode dispatch from MBRU,
//    - a Z-flag conditional branch.
//  - Also handles run start, halt on NOP and illegal-opcode trap, and counts dispatched instructions.
// PARAMETERS
//  UA_W        6   micro-address width
//  ROM_DEPTH   66  valid micro-addresses 0..ROM_DEPTH-1
//  FETCH1_A    0   first fetch micro-op / reset target
//  FETCH2_A    1   dispatch point (next = opcode)
//  NOP_A       46  halt micro-op
//  JUMPNZ_A    47  conditional: Z=0 -> JMPNZ1_A, Z=1 -> JMPZY1_A
//  JMPNZ1_A    48
//  JUMPZ_A     52  conditional: Z=0 -> JMPZN1_A, Z=1 -> JMPZY1_A
//  JMPZN1_A    53
//  JMPZY1_A    54
//  CNT_W       16  instruction counter width
// PORTS
//  clk         in   1      system clock, rising edge
//  rst_n       in   1      asynchronous active-low reset
//  enable      in   1      run request; rising edge starts a program
//  stall       in   1      memory wait; freezes sequencer when 1
//  next_field  in   UA_W   control word [37:32] for current uaddr (combinational from ROM)
//  opcode      in   UA_W   MBRU contents
//  z_flag      in   1      ALU zero flag
//  uaddr       out  UA_W   current micro-address to control store
//  running     out  1      1 while in RUN
//  finish      out  1      1 after NOP reached, held
//  trap        out  1      1 after illegal opcode dispatch, held
//  instr_count out  CNT_W  number of dispatches since last start
// BEHAVIOUR
//  Reset (async, rst_n=0):
//  - state=IDLE, uaddr=FETCH1_A, running=0, finish=0, trap=0, instr_count=0, enable_q=0.
//  States: IDLE, RUN, HALT. enable_q <= enable every cycle; start = enable & ~enable_q.
//  IDLE:
//  - start -> RUN.
//  - uaddr=FETCH1_A, finish=0, trap=0, instr_count=0 on entry.
//  - First RUN cycle presents FETCH1_A.
//  RUN, stall=1:
//  - All registers hold.
//  - No branch, halt or count evaluation.
//  RUN, stall=0, next uaddr by priority on current uaddr:
//  - NOP_A: -> HALT, finish<=1, uaddr holds NOP_A.
//  - FETCH2_A, opcode>=ROM_DEPTH: -> HALT, trap<=1, uaddr<=FETCH1_A.
//  - FETCH2_A, valid opcode: uaddr<=opcode, instr_count<=instr_count+1 (wraps mod 2^CNT_W).
//  - JUMPNZ_A: uaddr<= z_flag ? JMPZY1_A : JMPNZ1_A.
//  - JUMPZ_A: uaddr<= z_flag ? JMPZY1_A : JMPZN1_A.
//  - otherwise: uaddr<=next_field; next_field>=ROM_DEPTH -> HALT, trap<=1.
//  - z_flag is sampled on the same edge that leaves the JUMP address; one-cycle branch latency.
//  HALT:
//  - uaddr, finish, trap, instr_count hold; running=0.
//  - start -> RUN: uaddr<=FETCH1_A, finish<=0, trap<=0, instr_count<=0.
//  - start in RUN is ignored.
//  General:
//  - running = (state==RUN), registered.
//  - finish and trap are mutually exclusive.
//  - Reset mid-RUN aborts immediately to the reset values; no partial state survives.
// TESTING
//  1. Reset with enable=0 -> uaddr=0, running=0, finish=0, trap=0, count=0; hold 10 cycles unchanged.
//  2. Start pulse, opcode=2, next_field(0)=1, next_field(2)=0 ->
//     uaddr sequence 0,1,2,0 on successive edges; count=1 after dispatch.
//  3. uaddr=47 with z_flag=0 -> 48; with z_flag=1 -> 54.
//     uaddr=52 with z_flag=0 -> 53; with z_flag=1 -> 54.
//  4. stall=1 for 3 cycles at uaddr=1, opcode changes mid-stall ->
//     uaddr stays 1, count unchanged; dispatches opcode present when stall drops.
//  5. Dispatch opcode=46 -> next edge uaddr=46, following edge finish=1, running=0;
//     new enable rising edge -> uaddr=0, finish=0, count=0.
//  6. Dispatch opcode=6'h3F -> trap=1, uaddr=0, running=0;
//     assert rst_n=0 mid-RUN at uaddr=21 -> all outputs at reset values without a clock edge.

Source files
------------

// File: rtl/micro_sequencer.sv
// Micro-PC / next-address unit feeding the control-store ROM.
// Selects the next micro-address from the control word's next-address field,
// the opcode dispatch or a Z-flag branch. It also handles run start, halt on NOP,
// the illegal-address trap and the count of dispatched instructions.
module micro_sequencer #(
    parameter int unsigned UA_W      = 6,
    parameter int unsigned ROM_DEPTH = 66,
    parameter int unsigned FETCH1_A  = 0,
    parameter int unsigned FETCH2_A  = 1,
    parameter int unsigned NOP_A     = 46,
    parameter int unsigned JUMPNZ_A  = 47,
    parameter int unsigned JMPNZ1_A  = 48,
    parameter int unsigned JUMPZ_A   = 52,
    parameter int unsigned JMPZN1_A  = 53,
    parameter int unsigned JMPZY1_A  = 54,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             stall,
    input  logic [UA_W-1:0]  next_field,
    input  logic [UA_W-1:0]  opcode,
    input  logic             z_flag,
    output logic [UA_W-1:0]  uaddr,
    output logic             running,
    output logic             finish,
    output logic             trap,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [UA_W-1:0] Fetch1 = UA_W'(FETCH1_A);
    localparam logic [UA_W-1:0] Fetch2 = UA_W'(FETCH2_A);
    localparam logic [UA_W-1:0] Nop    = UA_W'(NOP_A);
    localparam logic [UA_W-1:0] JumpNz = UA_W'(JUMPNZ_A);
    localparam logic [UA_W-1:0] JmpNz1 = UA_W'(JMPNZ1_A);
    localparam logic [UA_W-1:0] JumpZ  = UA_W'(JUMPZ_A);
    localparam logic [UA_W-1:0] JmpZn1 = UA_W'(JMPZN1_A);
    localparam logic [UA_W-1:0] JmpZy1 = UA_W'(JMPZY1_A);

    typedef enum logic [1:0] {StIdle, StRun, StHalt} state_e;

    state_e           state_q, state_d;
    logic [UA_W-1:0]  uaddr_q, uaddr_d;
    logic             finish_q, finish_d;
    logic             trap_q, trap_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             enable_q;
    logic             running_q;
    logic             start;
    logic             opcode_bad;
    logic             next_bad;

    assign start = enable & ~enable_q;

    // Addresses at or beyond the ROM depth have no control word behind them.
    assign opcode_bad = 32'(opcode) >= ROM_DEPTH;
    assign next_bad   = 32'(next_field) >= ROM_DEPTH;

    // Next-state and next-address selection.
    always_comb begin
        state_d  = state_q;
        uaddr_d  = uaddr_q;
        finish_d = finish_q;
        trap_d   = trap_q;
        count_d  = count_q;
        unique case (state_q)
            StIdle, StHalt: begin
                if (start) begin
                    state_d  = StRun;
                    uaddr_d  = Fetch1;
                    finish_d = 1'b0;
                    trap_d   = 1'b0;
                    count_d  = '0;
                end
            end
            StRun: begin
                // A stalled memory access freezes everything, including branch evaluation.
                if (!stall) begin
                    if (uaddr_q == Nop) begin
                        state_d  = StHalt;
                        finish_d = 1'b1;
                    end else if (uaddr_q == Fetch2) begin
                        if (opcode_bad) begin
                            state_d = StHalt;
                            trap_d  = 1'b1;
                            uaddr_d = Fetch1;
                        end else begin
                            uaddr_d = opcode;
                            count_d = count_q + CNT_W'(1);
                        end
                    end else if (uaddr_q == JumpNz) begin
                        uaddr_d = z_flag ? JmpZy1 : JmpNz1;
                    end else if (uaddr_q == JumpZ) begin
                        uaddr_d = z_flag ? JmpZy1 : JmpZn1;
                    end else begin
                        uaddr_d = next_field;
                        if (next_bad) begin
                            state_d = StHalt;
                            trap_d  = 1'b1;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State, address, flag and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            uaddr_q   <= Fetch1;
            finish_q  <= 1'b0;
            trap_q    <= 1'b0;
            count_q   <= '0;
            enable_q  <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            uaddr_q   <= uaddr_d;
            finish_q  <= finish_d;
            trap_q    <= trap_d;
            count_q   <= count_d;
            enable_q  <= enable;
            running_q <= (state_d == StRun);
        end
    end

    assign uaddr       = uaddr_q;
    assign running     = running_q;
    assign finish      = finish_q;
    assign trap        = trap_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// Self-checking bench for micro_sequencer: directed scenarios followed by random
// stimulus, all compared against a behavioural model of the sequencing rules.
module tb_micro_sequencer;

    // The default ROM depth exceeds the 6-bit address space, which would leave the
    // illegal-address trap unreachable; a smaller depth exercises it.
    localparam int ROMD = 60;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        stall;
    logic [5:0]  next_field;
    logic [5:0]  opcode;
    logic        z_flag;
    logic [5:0]  uaddr;
    logic        running;
    logic        finish;
    logic        trap;
    logic [15:0] instr_count;

    micro_sequencer #(.ROM_DEPTH(ROMD)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .stall       (stall),
        .next_field  (next_field),
        .opcode      (opcode),
        .z_flag      (z_flag),
        .uaddr       (uaddr),
        .running     (running),
        .finish      (finish),
        .trap        (trap),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model: a program is either not started, running or stopped.
    bit m_active;
    bit m_started;
    int m_ua;
    bit m_fin;
    bit m_trap;
    int m_cnt;
    bit m_en_prev;

    int rom [64];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        check_eq({tag, "_uaddr"}, 32'(uaddr), 32'(m_ua));
        check_eq({tag, "_running"}, 32'(running), 32'(m_active));
        check_eq({tag, "_finish"}, 32'(finish), 32'(m_fin));
        check_eq({tag, "_trap"}, 32'(trap), 32'(m_trap));
        check_eq({tag, "_count"}, 32'(instr_count), 32'(m_cnt));
    endtask

    function automatic void model_reset();
        m_active  = 1'b0;
        m_started = 1'b0;
        m_ua      = 0;
        m_fin     = 1'b0;
        m_trap    = 1'b0;
        m_cnt     = 0;
        m_en_prev = 1'b0;
    endfunction

    // One clock edge: predict from the current inputs, clock, then compare.
    task automatic tick(input string tag);
        bit go;
        go = enable && !m_en_prev;
        if (m_active) begin
            if (!stall) begin
                if (m_ua == 46) begin
                    m_active = 1'b0;
                    m_fin    = 1'b1;
                end else if (m_ua == 1) begin
                    if (int'(opcode) >= ROMD) begin
                        m_active = 1'b0;
                        m_trap   = 1'b1;
                        m_ua     = 0;
                    end else begin
                        m_ua  = int'(opcode);
                        m_cnt = (m_cnt + 1) % 65536;
                    end
                end else if (m_ua == 47) begin
                    m_ua = z_flag ? 54 : 48;
                end else if (m_ua == 52) begin
                    m_ua = z_flag ? 54 : 53;
                end else begin
                    m_ua = int'(next_field);
                    if (m_ua >= ROMD) begin
                        m_active = 1'b0;
                        m_trap   = 1'b1;
                    end
                end
            end
        end else if (go) begin
            m_active  = 1'b1;
            m_started = 1'b1;
            m_ua      = 0;
            m_fin     = 1'b0;
            m_trap    = 1'b0;
            m_cnt     = 0;
        end
        m_en_prev = enable;
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    // Advance with the ROM's next-address field until the dispatch point, then dispatch op.
    task automatic goto_dispatch(input int op);
        int budget;
        budget = 20;
        while (m_ua != 1 && budget > 0) begin
            next_field = 6'(rom[m_ua]);
            tick("walk");
            budget--;
        end
        check_eq("reach_dispatch", 32'(uaddr), 32'd1);
        opcode = 6'(op);
        tick("dispatch");
        check_eq("dispatched", 32'(uaddr), 32'(op));
    endtask

    // Assert reset between edges and check that outputs clear without a clock.
    task automatic async_reset(input string tag);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic restart();
        enable = 1'b0;
        tick("restart_lo");
        enable = 1'b1;
        tick("restart_hi");
    endtask

    initial begin
        int cnt_before;
        for (int i = 0; i < 64; i++) rom[i] = 0;
        rom[0]  = 1;
        rom[5]  = 62;
        rom[10] = 11;
        rom[11] = 47;
        rom[12] = 52;

        enable     = 1'b0;
        stall      = 1'b0;
        next_field = 6'd1;
        opcode     = 6'd0;
        z_flag     = 1'b0;
        rst_n      = 1'b0;
        model_reset();
        #1;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Idle with enable low stays at reset values.
        for (int i = 0; i < 10; i++) tick("idle");

        // Start, fetch, dispatch opcode 2, return to fetch.
        enable     = 1'b1;
        next_field = 6'(rom[0]);
        tick("start");
        check_eq("seq0", 32'(uaddr), 32'd0);
        opcode = 6'd2;
        tick("fetch1");
        check_eq("seq1", 32'(uaddr), 32'd1);
        tick("fetch2");
        check_eq("seq2", 32'(uaddr), 32'd2);
        check_eq("seq2_cnt", 32'(instr_count), 32'd1);
        next_field = 6'(rom[2]);
        tick("exec2");
        check_eq("seq3", 32'(uaddr), 32'd0);

        // Conditional branches in both polarities.
        goto_dispatch(47);
        z_flag = 1'b0;
        tick("jnz");
        check_eq("jnz_z0", 32'(uaddr), 32'd48);
        goto_dispatch(47);
        z_flag = 1'b1;
        tick("jnz");
        check_eq("jnz_z1", 32'(uaddr), 32'd54);
        goto_dispatch(52);
        z_flag = 1'b0;
        tick("jz");
        check_eq("jz_z0", 32'(uaddr), 32'd53);
        goto_dispatch(52);
        z_flag = 1'b1;
        tick("jz");
        check_eq("jz_z1", 32'(uaddr), 32'd54);

        // Stall at the dispatch point while the opcode changes.
        next_field = 6'(rom[m_ua]);
        tick("pre_stall");
        next_field = 6'(rom[m_ua]);
        tick("pre_stall");
        cnt_before = m_cnt;
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            opcode = 6'(20 + i);
            tick("stall");
            check_eq("stall_ua", 32'(uaddr), 32'd1);
            check_eq("stall_cnt", 32'(instr_count), 32'(cnt_before));
        end
        opcode = 6'd3;
        stall  = 1'b0;
        tick("unstall");
        check_eq("unstall_ua", 32'(uaddr), 32'd3);

        // NOP halts; a fresh enable edge restarts with cleared state.
        goto_dispatch(46);
        tick("nop");
        check_eq("nop_finish", 32'(finish), 32'd1);
        check_eq("nop_running", 32'(running), 32'd0);
        enable = 1'b1;
        for (int i = 0; i < 3; i++) tick("halt_hold");
        restart();
        check_eq("restart_ua", 32'(uaddr), 32'd0);
        check_eq("restart_fin", 32'(finish), 32'd0);
        check_eq("restart_cnt", 32'(instr_count), 32'd0);

        // Illegal opcode traps to fetch and stops.
        next_field = 6'(rom[0]);
        tick("fetch1");
        opcode = 6'h3F;
        tick("bad_op");
        check_eq("trap_flag", 32'(trap), 32'd1);
        check_eq("trap_ua", 32'(uaddr), 32'd0);
        check_eq("trap_running", 32'(running), 32'd0);

        // Asynchronous reset in the middle of a program.
        restart();
        goto_dispatch(21);
        async_reset("midrun_reset");

        // Random phase.
        for (int i = 0; i < 3000; i++) begin
            if (m_active) enable = ($urandom_range(0, 15) != 0);
            else          enable = $urandom_range(0, 1) == 1;
            stall  = ($urandom_range(0, 3) == 0);
            z_flag = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 3) == 0) opcode = 6'($urandom_range(0, 63));
            else opcode = 6'($urandom_range(2, 12));
            if ($urandom_range(0, 9) == 0) next_field = 6'($urandom_range(0, 63));
            else next_field = 6'(rom[m_ua]);
            if ($urandom_range(0, 399) == 0) async_reset("rand_reset");
            else tick("rand");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
